// File: rtl/fp_multiplier_seq_if.sv
// Operand/result handshake bundle for the sequential binary32 multiplier.
// The master side supplies operands and consumes results; the slave is the multiplier.
interface fp_multiplier_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] input1;
    logic [31:0] input2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] opt;
    logic        overflow;
    logic        underflow;
    logic        exception;

    modport master (
        output in_valid, input1, input2, out_ready,
        input  in_ready, out_valid, opt, overflow, underflow, exception
    );

    modport slave (
        input  in_valid, input1, input2, out_ready,
        output in_ready, out_valid, opt, overflow, underflow, exception
    );
endinterface

// File: rtl/fp_multiplier_seq.sv
// Sequential IEEE-754 single-precision multiplier: 24-cycle shift-add mantissa product,
// then one normalize/truncate cycle; flag set matches the companion FP divider.
module fp_multiplier_seq (
    input  logic                 clk,
    input  logic                 rst_n,
    fp_multiplier_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } state_t;

    state_t      r_state;
    logic        r_sign;
    logic [7:0]  r_exp1;
    logic [7:0]  r_exp2;
    logic [23:0] r_ma;
    logic [23:0] r_mb;
    logic [47:0] r_acc;
    logic [4:0]  r_cnt;
    logic        r_inReady;
    logic        r_outValid;
    logic [31:0] r_opt;
    logic        r_overflow;
    logic        r_underflow;
    logic        r_exception;

    logic [47:0]       w_partial;
    logic signed [9:0] w_expSum;
    logic [22:0]       w_mant;
    logic [31:0]       w_normOpt;
    logic              w_normOvf;
    logic              w_normUnf;
    logic              w_normExc;
    logic              w_unusedAccLow;

    assign w_partial = r_mb[0] ? ({24'b0, r_ma} << r_cnt) : 48'b0;

    // Product exponent is biased twice, so one bias comes off; P[47] marks a 2.x product.
    assign w_expSum = $signed({2'b00, r_exp1}) + $signed({2'b00, r_exp2})
                    - 10'sd127 + $signed({9'b0, r_acc[47]});
    assign w_mant   = r_acc[47] ? r_acc[46:24] : r_acc[45:23];

    // Truncation discards the low product bits entirely.
    assign w_unusedAccLow = ^r_acc[22:0];

    always_comb begin
        w_normOpt = 32'h0;
        w_normOvf = 1'b0;
        w_normUnf = 1'b0;
        w_normExc = 1'b0;
        if (r_exp1 == 8'hFF || r_exp2 == 8'hFF) begin
            w_normOpt = 32'h7FC0_0000;
            w_normExc = 1'b1;
        end else if (r_exp1 == 8'h00 || r_exp2 == 8'h00) begin
            w_normOpt = {r_sign, 31'b0};
        end else if (w_expSum >= 10'sd255) begin
            w_normOpt = {r_sign, 8'hFF, 23'b0};
            w_normOvf = 1'b1;
        end else if (w_expSum <= 10'sd0) begin
            w_normOpt = {r_sign, 31'b0};
            w_normUnf = 1'b1;
        end else begin
            w_normOpt = {r_sign, w_expSum[7:0], w_mant};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sign      <= 1'b0;
            r_exp1      <= 8'h0;
            r_exp2      <= 8'h0;
            r_ma        <= 24'h0;
            r_mb        <= 24'h0;
            r_acc       <= 48'h0;
            r_cnt       <= 5'd0;
            r_inReady   <= 1'b1;
            r_outValid  <= 1'b0;
            r_opt       <= 32'h0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_exception <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid && r_inReady) begin
                        r_sign    <= bus.input1[31] ^ bus.input2[31];
                        r_exp1    <= bus.input1[30:23];
                        r_exp2    <= bus.input2[30:23];
                        r_ma      <= {1'b1, bus.input1[22:0]};
                        r_mb      <= {1'b1, bus.input2[22:0]};
                        r_acc     <= 48'h0;
                        r_cnt     <= 5'd0;
                        r_inReady <= 1'b0;
                        r_state   <= MUL;
                    end
                end
                MUL: begin
                    r_acc <= r_acc + w_partial;
                    r_mb  <= r_mb >> 1;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd23) begin
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    r_opt       <= w_normOpt;
                    r_overflow  <= w_normOvf;
                    r_underflow <= w_normUnf;
                    r_exception <= w_normExc;
                    r_outValid  <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (r_outValid && bus.out_ready) begin
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_inReady  <= 1'b1;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_inReady;
    assign bus.out_valid = r_outValid;
    assign bus.opt       = r_opt;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
    assign bus.exception = r_exception;

endmodule

// File: tb/tb_fp_multiplier_seq.sv
// Bench for fp_multiplier_seq: directed cases plus random operands checked against an
// arithmetic reference model, with latency, backpressure and mid-operation reset.
module tb_fp_multiplier_seq;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    fp_multiplier_seq_if bus ();

    fp_multiplier_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] flagsNow();
        return {29'b0, bus.overflow, bus.underflow, bus.exception};
    endfunction

    // Returns {opt, overflow, underflow, exception} from the IEEE rules with plain arithmetic.
    function automatic logic [34:0] refModel(input logic [31:0] a, input logic [31:0] b);
        logic        sign;
        logic [47:0] prod;
        logic [22:0] mant;
        logic [7:0]  expByte;
        int          e;
        sign = a[31] ^ b[31];
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {32'h7FC0_0000, 3'b001};
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {sign, 31'b0, 3'b000};
        prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127 + (prod[47] ? 1 : 0);
        mant = prod[47] ? prod[46:24] : prod[45:23];
        if (e >= 255) return {sign, 8'hFF, 23'b0, 3'b100};
        if (e <= 0) return {sign, 31'b0, 3'b010};
        expByte = 8'(e);
        return {sign, expByte, mant, 3'b000};
    endfunction

    task automatic sendOperands(input logic [31:0] a, input logic [31:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("inReadyBeforeSend", {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.input1   = a;
        bus.input2   = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("inReadyAfterAccept", {31'b0, bus.in_ready}, 32'd0);
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expOpt, input logic [2:0] expFlags,
                                 input int holdCycles);
        int edges;
        sendOperands(a, b);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!bus.out_valid && edges < 40);
        checkOutput("latency", 32'(edges), 32'd25);
        checkOutput("opt", bus.opt, expOpt);
        checkOutput("flags", flagsNow(), {29'b0, expFlags});
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.input1   = $urandom;
            bus.input2   = $urandom;
            @(posedge clk);
            #1;
            checkOutput("holdOpt", bus.opt, expOpt);
            checkOutput("holdInReady", {31'b0, bus.in_ready}, 32'd0);
            checkOutput("holdOutValid", {31'b0, bus.out_valid}, 32'd1);
        end
        // in_valid is raised on the completing edge; it must not be taken until IDLE.
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("releaseOutValid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("releaseInReady", {31'b0, bus.in_ready}, 32'd1);
        checkOutput("releaseOptKept", bus.opt, expOpt);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "InReady"}, {31'b0, bus.in_ready}, 32'd1);
        checkOutput({tag, "OutValid"}, {31'b0, bus.out_valid}, 32'd0);
        checkOutput({tag, "Opt"}, bus.opt, 32'h0);
        checkOutput({tag, "Flags"}, flagsNow(), 32'h0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expOpt;
        logic [2:0]  expFlags;
        int          hold;
    } directed_t;

    directed_t directed [$];

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.input1    = 32'h4000_0000;
        bus.input2    = 32'h4040_0000;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;

        directed.push_back('{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000, 0});
        directed.push_back('{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 3'b000, 0});
        directed.push_back('{32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 3'b000, 2});
        directed.push_back('{32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 3'b100, 0});
        directed.push_back('{32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 3'b010, 0});
        directed.push_back('{32'h0000_0000, 32'h4040_0000, 32'h0000_0000, 3'b000, 0});
        directed.push_back('{32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 3'b001, 0});
        directed.push_back('{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b001, 0});
        directed.push_back('{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000, 10});
        foreach (directed[i]) begin
            applyStimulus(directed[i].a, directed[i].b, directed[i].expOpt,
                          directed[i].expFlags, directed[i].hold);
        end

        // Abort during MUL; the previous nonzero result must vanish immediately.
        sendOperands(32'h3FC0_0000, 32'h4110_0000);
        repeat (12) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midReset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000, 0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [34:0] expected;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: a[30:23] = 8'hFF;
                1: b[30:23] = 8'h00;
                2: begin a[30:23] = 8'($urandom_range(1, 40));   b[30:23] = 8'($urandom_range(1, 90)); end
                3: begin a[30:23] = 8'($urandom_range(200, 254)); b[30:23] = 8'($urandom_range(120, 254)); end
                4: begin a[30:23] = 8'($urandom_range(100, 150)); b[30:23] = 8'($urandom_range(100, 150)); end
                default: ;
            endcase
            expected = refModel(a, b);
            applyStimulus(a, b, expected[34:3], expected[2:0], int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
